cache_ri: RTL

Replace/IO responder for the L1 cache. Accepts miss, IO and control commands from the cache read/write front end over the `ri_cmd` valid/ready handshake and services them. IO accesses go straight to the external master bus. Line misses evict a victim way, write it back if dirty, refill it, and update its tag and data-readable (dre) bits. Control commands invalidate the whole cache.

---
 rtl/cache_ri.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_ri.sv
// rtl/cache_ri.sv - replace/IO responder for the L1 cache
// Services line refills (with dirty write-back), uncached bus accesses and whole-cache invalidation.
module cache_ri #(
  parameter int SIZE            = 8 * 1024,
  parameter int DATA_ADDR_WIDTH = $clog2(SIZE / 16),
  parameter int SET_WIDTH       = DATA_ADDR_WIDTH - 4,
  parameter int TAG_ADDR_WIDTH  = 32 - (DATA_ADDR_WIDTH + 2)
) (
  input  logic                         clk,
  input  logic                         rest,
  input  logic [3:0]                   ri_cmd,
  input  logic                         ri_cmd_valid,
  output logic                         ri_cmd_ready,
  output logic [31:0]                  ri_rsp_data,
  input  logic [31:0]                  rw_address,
  input  logic [3:0]                   rw_byteEnable,
  input  logic                         rw_read,
  input  logic                         rw_write,
  input  logic [31:0]                  rw_writeData,
  output logic                         ri_isRequest,
  input  logic                         ctr_invalidate,
  output logic [31:0]                  m0_address,
  output logic [3:0]                   m0_byteEnable,
  output logic                         m0_read,
  output logic                         m0_write,
  output logic [31:0]                  m0_writeData,
  input  logic [31:0]                  m0_readData,
  input  logic                         m0_waitRequest,
  input  logic                         m0_readDataValid,
  output logic [DATA_ADDR_WIDTH-1:0]   data_address,
  output logic [1:0]                   data_channel,
  output logic                         data_writeEnable,
  output logic [31:0]                  data_writeData,
  input  logic [31:0]                  data_readData,
  output logic [SET_WIDTH-1:0]         tag_address,
  output logic [1:0]                   tag_channel,
  input  logic [31:0]                  tag_readData,
  output logic                         tag_writeEnable,
  output logic [31:0]                  tag_writeData,
  input  logic                         tag_isHaveFreeBlock,
  input  logic [1:0]                   tag_freeBlockNum,
  output logic [DATA_ADDR_WIDTH-2:0]   dre_address,
  output logic [1:0]                   dre_channel,
  output logic                         dre_writeEnable,
  output logic [7:0]                   dre_writeData
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] IO_REQ    = 4'd1;
  localparam logic [3:0] IO_WAIT   = 4'd2;
  localparam logic [3:0] VICTIM    = 4'd3;
  localparam logic [3:0] WB_RD     = 4'd4;
  localparam logic [3:0] WB_REQ    = 4'd5;
  localparam logic [3:0] FILL_REQ  = 4'd6;
  localparam logic [3:0] FILL_WAIT = 4'd7;
  localparam logic [3:0] TAG_WR    = 4'd8;
  localparam logic [3:0] INV       = 4'd9;
  localparam logic [3:0] DONE      = 4'd10;

  localparam logic [3:0] CMD_RB   = 4'd1;
  localparam logic [3:0] CMD_IORW = 4'd2;
  localparam logic [3:0] CMD_CTR  = 4'd3;

  logic [3:0]                state;
  logic                      victimPhase;
  logic [1:0]                way;
  logic [1:0]                rr;
  logic [3:0]                word;
  logic [TAG_ADDR_WIDTH-1:0] oldTag;
  logic [31:0]               rspData;
  logic                      isRequest;
  logic [SET_WIDTH+1:0]      invCount;

  logic [SET_WIDTH-1:0]      setIdx;
  logic [TAG_ADDR_WIDTH-1:0] curTag;
  logic [1:0]                wayPick;
  logic                      invLast;
  logic                      unusedTagBits;

  assign setIdx        = rw_address[DATA_ADDR_WIDTH+1:6];
  assign curTag        = rw_address[31:DATA_ADDR_WIDTH+2];
  assign wayPick       = tag_isHaveFreeBlock ? tag_freeBlockNum : rr;
  assign invLast       = &invCount;
  assign unusedTagBits = ^tag_readData[29:TAG_ADDR_WIDTH];

  assign ri_isRequest = isRequest;
  assign ri_rsp_data  = rspData;

  always_ff @(posedge clk) begin
    if (rest) begin
      state       <= IDLE;
      victimPhase <= 1'b0;
      way         <= 2'd0;
      rr          <= 2'd0;
      word        <= 4'd0;
      oldTag      <= '0;
      rspData     <= 32'd0;
      isRequest   <= 1'b0;
      invCount    <= '0;
    end else begin
      // A new invalidate request beats the clear in INV's final cycle.
      if (ctr_invalidate)
        isRequest <= 1'b1;
      else if (state == INV && invLast)
        isRequest <= 1'b0;

      case (state)
        IDLE: begin
          if (ri_cmd_valid) begin
            word        <= 4'd0;
            victimPhase <= 1'b0;
            invCount    <= '0;
            case (ri_cmd)
              CMD_IORW: state <= IO_REQ;
              CMD_RB:   state <= VICTIM;
              CMD_CTR:  state <= INV;
              default:  state <= DONE;
            endcase
          end
        end
        IO_REQ: begin
          if (!m0_waitRequest)
            state <= rw_write ? DONE : IO_WAIT;
        end
        IO_WAIT: begin
          if (m0_readDataValid) begin
            rspData <= m0_readData;
            state   <= DONE;
          end
        end
        VICTIM: begin
          // Phase 0 picks the way and addresses the tag RAM; phase 1 sees its tag.
          if (!victimPhase) begin
            way         <= wayPick;
            victimPhase <= 1'b1;
            if (!tag_isHaveFreeBlock)
              rr <= rr + 2'd1;
          end else begin
            oldTag <= tag_readData[TAG_ADDR_WIDTH-1:0];
            state  <= (tag_readData[31] && tag_readData[30]) ? WB_RD : FILL_REQ;
          end
        end
        WB_RD: state <= WB_REQ;
        WB_REQ: begin
          if (!m0_waitRequest) begin
            word  <= word + 4'd1;
            state <= (word == 4'd15) ? FILL_REQ : WB_RD;
          end
        end
        FILL_REQ: begin
          if (!m0_waitRequest)
            state <= FILL_WAIT;
        end
        FILL_WAIT: begin
          if (m0_readDataValid) begin
            if (word == rw_address[5:2])
              rspData <= m0_readData;
            word  <= word + 4'd1;
            state <= (word == 4'd15) ? TAG_WR : FILL_REQ;
          end
        end
        TAG_WR: state <= DONE;
        INV: begin
          invCount <= invCount + 1'b1;
          if (invLast)
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM write enables are gated by reset so nothing lands in the reset cycle.
  always_comb begin
    ri_cmd_ready     = 1'b0;
    m0_address       = 32'd0;
    m0_byteEnable    = 4'd0;
    m0_read          = 1'b0;
    m0_write         = 1'b0;
    m0_writeData     = 32'd0;
    data_address     = '0;
    data_channel     = 2'd0;
    data_writeEnable = 1'b0;
    data_writeData   = 32'd0;
    tag_address      = '0;
    tag_channel      = 2'd0;
    tag_writeEnable  = 1'b0;
    tag_writeData    = 32'd0;
    dre_address      = '0;
    dre_channel      = 2'd0;
    dre_writeEnable  = 1'b0;
    dre_writeData    = 8'd0;
    case (state)
      IO_REQ: begin
        m0_address    = rw_address;
        m0_byteEnable = rw_byteEnable;
        m0_read       = rw_read;
        m0_write      = rw_write;
        m0_writeData  = rw_writeData;
      end
      VICTIM: begin
        tag_address = setIdx;
        tag_channel = victimPhase ? way : wayPick;
      end
      WB_RD: begin
        data_address = {setIdx, word};
        data_channel = way;
      end
      WB_REQ: begin
        data_address  = {setIdx, word};
        data_channel  = way;
        m0_write      = 1'b1;
        m0_address    = {oldTag, setIdx, word, 2'b00};
        m0_byteEnable = 4'hF;
        m0_writeData  = data_readData;
      end
      FILL_REQ: begin
        data_address  = {setIdx, word};
        data_channel  = way;
        m0_read       = 1'b1;
        m0_address    = {rw_address[31:6], word, 2'b00};
        m0_byteEnable = 4'hF;
      end
      FILL_WAIT: begin
        data_address     = {setIdx, word};
        data_channel     = way;
        data_writeEnable = m0_readDataValid && !rest;
        data_writeData   = m0_readData;
        dre_address      = {setIdx, word[3:1]};
        dre_channel      = way;
        if (m0_readDataValid && word[0] && !rest) begin
          dre_writeEnable = 1'b1;
          dre_writeData   = 8'hFF;
        end
      end
      TAG_WR: begin
        tag_address     = setIdx;
        tag_channel     = way;
        tag_writeEnable = !rest;
        tag_writeData   = {1'b1, 1'b0, {(30 - TAG_ADDR_WIDTH){1'b0}}, curTag};
      end
      INV: begin
        tag_address     = invCount[SET_WIDTH+1:2];
        tag_channel     = invCount[1:0];
        tag_writeEnable = !rest;
      end
      DONE: ri_cmd_ready = 1'b1;
      default: ;
    endcase
  end

endmodule
